// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset/handler addresses, ExcCodes, NOP encoding,
// next-PC source selection and the IF/ID register layout.
package fetch_stage_pkg;

  localparam logic [31:0] START_ADDR_DEF = 32'h0000_3000;
  localparam logic [31:0] ISR_ADDR_DEF   = 32'h0000_4180;
  localparam logic [4:0]  EXC_CODE_NONE  = 5'd0;
  localparam logic [4:0]  EXC_CODE_ADEL  = 5'd4;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_REDIRECT,
    NPC_HOLD,
    NPC_ERET,
    NPC_EXC
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        exc;
    logic [4:0]  exc_code;
    logic        bd;
  } if_id_t;

  // Exceptions and ERET must redirect even while the hazard unit is stalling.
  function automatic npc_sel_e npc_select(input logic exc_req, input logic eret_req,
                                          input logic stall, input logic redirect_valid);
    if (exc_req)             return NPC_EXC;
    else if (eret_req)       return NPC_ERET;
    else if (stall)          return NPC_HOLD;
    else if (redirect_valid) return NPC_REDIRECT;
    else                     return NPC_SEQ;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter flop with the prioritised next-PC mux.
module fetch_stage_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] START_ADDR = START_ADDR_DEF,
  parameter logic [31:0] ISR_ADDR   = ISR_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  npc_sel_e    npc_sel;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  assign npc_sel = npc_select(exc_req, eret_req, stall, redirect_valid);

  always_comb begin
    pc_next = pc_reg + 32'd4;
    case (npc_sel)
      NPC_EXC:      pc_next = ISR_ADDR;
      NPC_ERET:     pc_next = epc;
      NPC_HOLD:     pc_next = pc_reg;
      NPC_REDIRECT: pc_next = redirect_pc;
      default:      pc_next = pc_reg + 32'd4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= START_ADDR;
    else        pc_reg <= pc_next;
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: drives the instruction address from the PC and captures the fetched
// word (or an AdEL-tagged bubble for a bad address) into the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] START_ADDR = START_ADDR_DEF,
  parameter logic [31:0] ISR_ADDR   = ISR_ADDR_DEF,
  parameter logic [4:0]  EXC_ADEL   = EXC_CODE_ADEL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_is_branch,
  output logic [31:0] im_addr,
  input  logic [31:0] im_result,
  input  logic        im_valid,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_exc,
  output logic [4:0]  if_id_exc_code,
  output logic        if_id_bd
);

  if_id_t if_id_reg;
  if_id_t if_id_next;

  fetch_stage_pc_reg #(
    .START_ADDR (START_ADDR),
    .ISR_ADDR   (ISR_ADDR)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .exc_req        (exc_req),
    .eret_req       (eret_req),
    .epc            (epc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  assign im_addr = pc;

  // A bubble still carries the current PC; a faulting fetch keeps its address for BadVAddr.
  always_comb begin
    if_id_next = if_id_reg;
    if (exc_req || eret_req || flush) begin
      if_id_next = '{instr: NOP_INSTR, pc: pc, valid: 1'b0, exc: 1'b0,
                     exc_code: EXC_CODE_NONE, bd: 1'b0};
    end else if (!stall) begin
      if (!im_valid) begin
        if_id_next = '{instr: NOP_INSTR, pc: pc, valid: 1'b1, exc: 1'b1,
                       exc_code: EXC_ADEL, bd: id_is_branch};
      end else begin
        if_id_next = '{instr: im_result, pc: pc, valid: 1'b1, exc: 1'b0,
                       exc_code: EXC_CODE_NONE, bd: id_is_branch};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_reg <= '{instr: NOP_INSTR, pc: START_ADDR, valid: 1'b0, exc: 1'b0,
                     exc_code: EXC_CODE_NONE, bd: 1'b0};
    end else begin
      if_id_reg <= if_id_next;
    end
  end

  assign if_id_instr    = if_id_reg.instr;
  assign if_id_pc       = if_id_reg.pc;
  assign if_id_valid    = if_id_reg.valid;
  assign if_id_exc      = if_id_reg.exc;
  assign if_id_exc_code = if_id_reg.exc_code;
  assign if_id_bd       = if_id_reg.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, exc_req, eret_req, redirect_valid, id_is_branch;
  logic [31:0] epc, redirect_pc;
  logic [31:0] im_addr, im_result, pc, if_id_instr, if_id_pc;
  logic        im_valid, if_id_valid, if_id_exc, if_id_bd;
  logic [4:0]  if_id_exc_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory: words 0x3000..0x4FFC exist, contents derived from the address.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a < 32'h0000_5000);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign im_valid  = addr_ok(im_addr);
  assign im_result = word_at(im_addr);

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .exc_req        (exc_req),
    .eret_req       (eret_req),
    .epc            (epc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_is_branch   (id_is_branch),
    .im_addr        (im_addr),
    .im_result      (im_result),
    .im_valid       (im_valid),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
    .if_id_exc      (if_id_exc),
    .if_id_exc_code (if_id_exc_code),
    .if_id_bd       (if_id_bd)
  );

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_exc, m_bd;
  logic [4:0]  m_code;

  task automatic model_reset();
    m_pc = 32'h3000; m_instr = 0; m_ipc = 32'h3000;
    m_valid = 0; m_exc = 0; m_code = 0; m_bd = 0;
  endtask

  task automatic model_step();
    logic [31:0] npc;
    if (exc_req)             npc = 32'h4180;
    else if (eret_req)       npc = epc;
    else if (stall)          npc = m_pc;
    else if (redirect_valid) npc = redirect_pc;
    else                     npc = m_pc + 32'd4;
    if (exc_req || eret_req || flush) begin
      m_instr = 0; m_ipc = m_pc; m_valid = 0; m_exc = 0; m_code = 0; m_bd = 0;
    end else if (!stall) begin
      m_ipc = m_pc; m_valid = 1; m_bd = id_is_branch;
      if (addr_ok(m_pc)) begin
        m_instr = word_at(m_pc); m_exc = 0; m_code = 0;
      end else begin
        m_instr = 0; m_exc = 1; m_code = 5'd4;
      end
    end
    m_pc = npc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pc"},    pc,                    m_pc);
    chk({tag, " instr"}, if_id_instr,           m_instr);
    chk({tag, " ipc"},   if_id_pc,              m_ipc);
    chk({tag, " valid"}, {31'd0, if_id_valid},  {31'd0, m_valid});
    chk({tag, " exc"},   {31'd0, if_id_exc},    {31'd0, m_exc});
    chk({tag, " code"},  {27'd0, if_id_exc_code}, {27'd0, m_code});
    chk({tag, " bd"},    {31'd0, if_id_bd},     {31'd0, m_bd});
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; exc_req = 0; eret_req = 0; epc = 0;
    redirect_valid = 0; redirect_pc = 0; id_is_branch = 0;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
    $display("%s: pc=%h if_id_pc=%h instr=%h v=%0d exc=%0d code=%0d bd=%0d",
             tag, pc, if_id_pc, if_id_instr, if_id_valid, if_id_exc, if_id_exc_code, if_id_bd);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check_model("reset");
  endtask

  typedef struct {
    logic st, fl, ex, er;
    logic [31:0] epc;
    logic rv;
    logic [31:0] rpc;
    logic br;
    logic [31:0] e_pc, e_ipc;
    logic e_valid, e_exc, e_bd;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // st fl ex er epc rv rpc br | pc ipc valid exc bd
    tbl[0]  = '{0,0,0,0,32'h0,   0,32'h0,   0, 32'h3004, 32'h3000, 1,0,0};
    tbl[1]  = '{0,0,0,0,32'h0,   0,32'h0,   0, 32'h3008, 32'h3004, 1,0,0};
    tbl[2]  = '{0,0,0,0,32'h0,   1,32'h3100,1, 32'h3100, 32'h3008, 1,0,1};
    tbl[3]  = '{0,0,0,0,32'h0,   0,32'h0,   0, 32'h3104, 32'h3100, 1,0,0};
    tbl[4]  = '{0,0,0,0,32'h0,   1,32'h3002,1, 32'h3002, 32'h3104, 1,0,1};
    tbl[5]  = '{0,0,0,0,32'h0,   0,32'h0,   0, 32'h3006, 32'h3002, 1,1,0};
    tbl[6]  = '{0,0,1,0,32'h0,   0,32'h0,   0, 32'h4180, 32'h3006, 0,0,0};
    tbl[7]  = '{0,0,0,0,32'h0,   0,32'h0,   0, 32'h4184, 32'h4180, 1,0,0};
    tbl[8]  = '{1,0,0,0,32'h0,   0,32'h0,   0, 32'h4184, 32'h4180, 1,0,0};
    tbl[9]  = '{1,0,0,0,32'h0,   1,32'h3200,1, 32'h4184, 32'h4180, 1,0,0};
    tbl[10] = '{1,0,0,0,32'h0,   1,32'h3200,1, 32'h4184, 32'h4180, 1,0,0};
    tbl[11] = '{0,0,0,0,32'h0,   1,32'h3200,1, 32'h3200, 32'h4184, 1,0,1};
    tbl[12] = '{1,0,1,0,32'h0,   0,32'h0,   0, 32'h4180, 32'h3200, 0,0,0};
    tbl[13] = '{0,0,0,1,32'h300C,0,32'h0,   0, 32'h300C, 32'h4180, 0,0,0};
    tbl[14] = '{0,0,0,0,32'h0,   0,32'h0,   0, 32'h3010, 32'h300C, 1,0,0};
    tbl[15] = '{1,1,0,0,32'h0,   0,32'h0,   0, 32'h3010, 32'h3010, 0,0,0};
    tbl[16] = '{0,0,1,1,32'h3000,0,32'h0,   0, 32'h4180, 32'h3010, 0,0,0};

    rst_n = 0;
    clear_inputs();
    #2;
    do_reset();

    // Directed table: sequential, branch with delay slot, fault, stall, exc/eret/flush.
    for (int i = 0; i < 17; i++) begin
      logic [31:0] e_instr;
      string tag;
      tag = $sformatf("vec%0d", i);
      stall = tbl[i].st; flush = tbl[i].fl; exc_req = tbl[i].ex; eret_req = tbl[i].er;
      epc = tbl[i].epc; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      id_is_branch = tbl[i].br;
      cycle(tag);
      e_instr = (tbl[i].e_valid && !tbl[i].e_exc) ? word_at(tbl[i].e_ipc) : 32'h0;
      chk({tag, " tbl pc"},    pc,       tbl[i].e_pc);
      chk({tag, " tbl ipc"},   if_id_pc, tbl[i].e_ipc);
      chk({tag, " tbl instr"}, if_id_instr, e_instr);
      chk({tag, " tbl valid"}, {31'd0, if_id_valid}, {31'd0, tbl[i].e_valid});
      chk({tag, " tbl exc"},   {31'd0, if_id_exc},   {31'd0, tbl[i].e_exc});
      chk({tag, " tbl code"},  {27'd0, if_id_exc_code}, tbl[i].e_exc ? 32'd4 : 32'd0);
      chk({tag, " tbl bd"},    {31'd0, if_id_bd},    {31'd0, tbl[i].e_bd});
    end
    clear_inputs();

    // PC wraps past 2^32 and both fetches fault.
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    cycle("wrap0");
    chk("wrap0 pc", pc, 32'hFFFF_FFFC);
    clear_inputs();
    cycle("wrap1");
    chk("wrap1 pc", pc, 32'h0);
    chk("wrap1 ipc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap1 exc", {31'd0, if_id_exc}, 32'd1);
    cycle("wrap2");
    chk("wrap2 ipc", if_id_pc, 32'h0);
    chk("wrap2 code", {27'd0, if_id_exc_code}, 32'd4);

    // Mid-run asynchronous reset, observed before any clock edge.
    rst_n = 0;
    #1;
    model_reset();
    chk("async rst pc", pc, 32'h3000);
    chk("async rst valid", {31'd0, if_id_valid}, 32'd0);
    chk("async rst ipc", if_id_pc, 32'h3000);
    chk("async rst exc", {31'd0, if_id_exc}, 32'd0);
    $display("async reset: pc=%h if_id_valid=%0d", pc, if_id_valid);
    #2 rst_n = 1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      stall          = ($urandom_range(0, 99) < 25);
      flush          = ($urandom_range(0, 99) < 10);
      exc_req        = ($urandom_range(0, 99) < 5);
      eret_req       = ($urandom_range(0, 99) < 5);
      epc            = 32'h3000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      redirect_valid = ($urandom_range(0, 99) < 15);
      redirect_pc    = 32'h3000 + {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3) == 0 ? 2 : 0)};
      id_is_branch   = redirect_valid | ($urandom_range(0, 99) < 10);
      cycle($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
